// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA HOLD/HLDA responder.
package dma_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } state_e;

    localparam int GRANT_CNT_W = 16;
    localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = '1;

    function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
        return (v == GRANT_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dma_hold_timeout.sv
// Grant-length counter: expire is a registered flag that is high exactly during
// the cycle whose count equals TIMEOUT_CYCLES-1.
module dma_hold_timeout #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;
    logic [TIMEOUT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else if (enable)
            count_nxt = count + 1'b1;
    end

    // Look ahead one cycle so the abort pulse lines up with the last grant cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            expire <= 1'b0;
        end else begin
            count  <= count_nxt;
            expire <= (clear | enable) && (count_nxt == LAST);
        end
    end

endmodule

// File: rtl/dma_hold_responder.sv
// CPU-side HOLD/HLDA responder: drains the CPU bus cycle, grants the bus, and
// enforces a release gap. Optional grant timeout under DMA_HOLD_TIMEOUT_EN.
module dma_hold_responder
    import dma_arb_pkg::*;
#(
    parameter int RELEASE_GAP    = 2,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hold_req,
    input  logic                   cpu_cycle_active,
    output logic                   cpu_stall,
    output logic                   hlda,
    output logic                   dma_bus_en,
    output logic                   timeout_abort,
    output logic [GRANT_CNT_W-1:0] grant_count
);

    if (RELEASE_GAP < 1 || RELEASE_GAP > 15) begin : g_bad_gap
        $error("RELEASE_GAP must be in 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 || TIMEOUT_CYCLES > (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255 and fit TIMEOUT_W bits");
    end

    state_e     state;
    logic [3:0] gap_cnt;
    logic       expire;

`ifdef DMA_HOLD_TIMEOUT_EN
    logic grant_entry;
    logic grant_stay;

    assign grant_entry = (state == DRAIN) && hold_req && !cpu_cycle_active;
    assign grant_stay  = (state == GRANT) && hold_req && !expire;

    dma_hold_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_entry),
        .enable (grant_stay),
        .expire (expire)
    );

    assign timeout_abort = expire;
`else
    assign expire        = 1'b0;
    assign timeout_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            cpu_stall   <= 1'b0;
            hlda        <= 1'b0;
            dma_bus_en  <= 1'b0;
            grant_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_req) begin
                        state     <= DRAIN;
                        cpu_stall <= 1'b1;
                    end
                end
                // A request that drops before the CPU finishes is abandoned silently.
                DRAIN: begin
                    if (!hold_req) begin
                        state     <= IDLE;
                        cpu_stall <= 1'b0;
                    end else if (!cpu_cycle_active) begin
                        state       <= GRANT;
                        hlda        <= 1'b1;
                        dma_bus_en  <= 1'b1;
                        grant_count <= sat_inc(grant_count);
                    end
                end
                GRANT: begin
                    if (!hold_req || expire) begin
                        state      <= RELEASE;
                        hlda       <= 1'b0;
                        dma_bus_en <= 1'b0;
                    end
                end
                RELEASE: begin
                    state     <= GAP;
                    cpu_stall <= 1'b0;
                    gap_cnt   <= 4'(RELEASE_GAP - 1);
                end
                // hold_req is deliberately not looked at here: the CPU gets its gap.
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    cpu_stall  <= 1'b0;
                    hlda       <= 1'b0;
                    dma_bus_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_hold_responder.sv
// Scoreboard bench for dma_hold_responder: per-cycle expected outputs are queued
// from the stimulus tables, then popped and compared after each clock edge.
module tb_dma_hold_responder;

    localparam int GAP_P = 2;
    localparam int TO_P  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hold_req = 1'b0;
    logic        cpu_cycle_active = 1'b0;
    logic        cpu_stall;
    logic        hlda;
    logic        dma_bus_en;
    logic        timeout_abort;
    logic [15:0] grant_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          gc = 0;
    logic [19:0] sb[$];

    always #5 clk = ~clk;

    dma_hold_responder #(
        .RELEASE_GAP    (GAP_P),
        .TIMEOUT_CYCLES (TO_P),
        .TIMEOUT_W      (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .hold_req         (hold_req),
        .cpu_cycle_active (cpu_cycle_active),
        .cpu_stall        (cpu_stall),
        .hlda             (hlda),
        .dma_bus_en       (dma_bus_en),
        .timeout_abort    (timeout_abort),
        .grant_count      (grant_count)
    );

    // Expected record: {stall, hlda, dma_bus_en, abort, grant_count}
    function automatic logic [19:0] ex(input bit s, input bit h, input bit a, input int g);
        logic [15:0] g16;
        g16 = g[15:0];
        return {s, h, h, a, g16};
    endfunction

    function automatic logic [19:0] obs();
        return {cpu_stall, hlda, dma_bus_en, timeout_abort, grant_count};
    endfunction

    task automatic test_reset();
        logic [19:0] got, want;
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            reset    = (i < 2);
            hold_req = (i < 2);
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
        gc = 0;
    endtask

    task automatic test_idle_grant();
        logic [19:0] got, want;
        for (int i = 0; i < 14; i++)
            sb.push_back(i == 0 ? ex(1, 0, 0, gc) : i <= 8 ? ex(1, 1, 0, gc + 1) :
                         i == 9 ? ex(1, 0, 0, gc + 1) : ex(0, 0, 0, gc + 1));
        for (int i = 0; i < 14; i++) begin
            hold_req = (i < 9); cpu_cycle_active = 1'b0;
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL idle_grant cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
        gc++;
    endtask

    task automatic test_busy_cpu();
        logic [19:0] got, want;
        for (int i = 0; i < 12; i++)
            sb.push_back(i <= 3 ? ex(1, 0, 0, gc) : i <= 7 ? ex(1, 1, 0, gc + 1) :
                         i == 8 ? ex(1, 0, 0, gc + 1) : ex(0, 0, 0, gc + 1));
        for (int i = 0; i < 12; i++) begin
            hold_req = (i < 8); cpu_cycle_active = (i < 4);
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL busy_cpu cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
        cpu_cycle_active = 1'b0;
        gc++;
    endtask

    task automatic test_abort_req();
        logic [19:0] got, want;
        bit h[6] = '{1, 0, 0, 1, 0, 0};
        bit b[6] = '{1, 1, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++)
            sb.push_back((i == 0 || i == 3) ? ex(1, 0, 0, gc) : ex(0, 0, 0, gc));
        for (int i = 0; i < 6; i++) begin
            hold_req = h[i]; cpu_cycle_active = b[i];
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL abort_req cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
    endtask

    // Reset first so the two grants read as grant_count 1 then 2.
    // hlda low for GAP_P+3 cycles; stall low for the GAP_P gap cycles plus the IDLE sampling cycle.
    task automatic test_back_to_back();
        logic [19:0] got, want;
        int j;
        sb.push_back(ex(0, 0, 0, 0));
        for (int i = 0; i < 15; i++)
            sb.push_back(i == 0 ? ex(1, 0, 0, 0) : i <= 3 ? ex(1, 1, 0, 1) : i == 4 ? ex(1, 0, 0, 1) :
                         i <= 7 ? ex(0, 0, 0, 1) : i == 8 ? ex(1, 0, 0, 1) : i <= 10 ? ex(1, 1, 0, 2) :
                         i == 11 ? ex(1, 0, 0, 2) : ex(0, 0, 0, 2));
        for (int i = 0; i < 16; i++) begin
            j = i - 1;
            reset    = (i == 0);
            hold_req = (i == 0) || ((j < 11) && (j != 4));
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL back_to_back cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
        gc = 2;
    endtask

    task automatic test_timeout();
        logic [19:0] got, want;
`ifdef DMA_HOLD_TIMEOUT_EN
        localparam int N = 19;
        localparam int HOLD_END = 15;
        for (int i = 0; i < N; i++)
            sb.push_back(i == 0 ? ex(1, 0, 0, gc) : i <= 7 ? ex(1, 1, 0, gc + 1) : i == 8 ? ex(1, 1, 1, gc + 1) :
                         i == 9 ? ex(1, 0, 0, gc + 1) : i <= 12 ? ex(0, 0, 0, gc + 1) :
                         i == 13 ? ex(1, 0, 0, gc + 1) : i == 14 ? ex(1, 1, 0, gc + 2) :
                         i == 15 ? ex(1, 0, 0, gc + 2) : ex(0, 0, 0, gc + 2));
`else
        localparam int N = 105;
        localparam int HOLD_END = 101;
        for (int i = 0; i < N; i++)
            sb.push_back(i == 0 ? ex(1, 0, 0, gc) : i <= 100 ? ex(1, 1, 0, gc + 1) :
                         i == 101 ? ex(1, 0, 0, gc + 1) : ex(0, 0, 0, gc + 1));
`endif
        for (int i = 0; i < N; i++) begin
            hold_req = (i < HOLD_END); cpu_cycle_active = 1'b0;
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL timeout cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
`ifdef DMA_HOLD_TIMEOUT_EN
        gc += 2;
`else
        gc += 1;
`endif
    endtask

    task automatic test_reset_mid_grant();
        logic [19:0] got, want;
        for (int i = 0; i < 6; i++)
            sb.push_back(i == 0 ? ex(1, 0, 0, gc) : i <= 2 ? ex(1, 1, 0, gc + 1) : ex(0, 0, 0, 0));
        for (int i = 0; i < 6; i++) begin
            reset    = (i == 3);
            hold_req = (i < 4);
            @(posedge clk); #1;
            want = sb.pop_front(); got = obs(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset_mid_grant cyc %0d: got %b gc=%0d, want %b gc=%0d", i, got[19:16], got[15:0], want[19:16], want[15:0]);
            end
        end
        gc = 0;
    endtask

    initial begin
        test_reset();
        test_idle_grant();
        test_busy_cpu();
        test_abort_req();
        test_back_to_back();
        test_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
